// File: rtl/agu_xlate_arbiter.sv
// Round-robin arbiter sharing one address-translation port between two AGUs,
// with a per-transaction timeout that answers with a fault code.
//
// state | meaning
// IDLE  | no transaction; grant the next requester
// WAIT  | request forwarded, waiting for the translation answer or timeout
// RESP  | one-cycle answer pulse on ans_vld_o, requests ignored
module agu_xlate_arbiter #(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [3:0]  LD_FAULT_CODE  = 4'd5,
    parameter logic [3:0]  ST_FAULT_CODE  = 4'd7
) (
    input  logic        cpu_clock_i,
    input  logic        cpu_reset_n_i,
    input  logic        flush_i,
    input  logic [1:0]  virt_addr_vld_i,
    input  logic [31:0] virt_addr0_i,
    input  logic [31:0] virt_addr1_i,
    input  logic [1:0]  isWrite_i,
    output logic        xl_req_vld_o,
    output logic [31:0] xl_addr_o,
    output logic        xl_write_o,
    input  logic        ans_vld_i,
    input  logic [31:0] translated_addr_i,
    input  logic [3:0]  excp_code_i,
    input  logic        excp_code_vld_i,
    output logic [1:0]  ans_vld_o,
    output logic [31:0] translated_addr_o,
    output logic [3:0]  excp_code_o,
    output logic        excp_code_vld_o,
    output logic        grant_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       r_state;
    logic             r_grant;
    logic             r_last_grant;
    logic             r_xl_req_vld;
    logic [31:0]      r_xl_addr;
    logic             r_xl_write;
    logic [1:0]       r_ans_vld;
    logic [31:0]      r_translated_addr;
    logic [3:0]       r_excp_code;
    logic             r_excp_code_vld;
    logic [CNT_W-1:0] r_wait_cnt;

    logic             w_any_req;
    logic             w_winner;
    logic             w_timeout;

    assign w_any_req = |virt_addr_vld_i;
    // On a tie the AGU that did not win last time takes the port.
    assign w_winner  = (&virt_addr_vld_i) ? ~r_last_grant : virt_addr_vld_i[1];
    assign w_timeout = (r_wait_cnt == CNT_LAST);

    always_ff @(posedge cpu_clock_i) begin
        if (!cpu_reset_n_i) begin
            r_state           <= IDLE;
            r_grant           <= 1'b0;
            r_last_grant      <= 1'b1;
            r_xl_req_vld      <= 1'b0;
            r_xl_addr         <= '0;
            r_xl_write        <= 1'b0;
            r_ans_vld         <= 2'b00;
            r_translated_addr <= '0;
            r_excp_code       <= '0;
            r_excp_code_vld   <= 1'b0;
            r_wait_cnt        <= '0;
        end else begin
            r_ans_vld <= 2'b00;
            if (flush_i) begin
                r_state      <= IDLE;
                r_xl_req_vld <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_any_req) begin
                            r_grant      <= w_winner;
                            r_last_grant <= w_winner;
                            r_xl_addr    <= w_winner ? virt_addr1_i : virt_addr0_i;
                            r_xl_write   <= isWrite_i[w_winner];
                            r_xl_req_vld <= 1'b1;
                            r_wait_cnt   <= '0;
                            r_state      <= WAIT;
                        end
                    end
                    WAIT: begin
                        if (ans_vld_i) begin
                            r_translated_addr   <= translated_addr_i;
                            r_excp_code         <= excp_code_i;
                            r_excp_code_vld     <= excp_code_vld_i;
                            r_ans_vld[r_grant]  <= 1'b1;
                            r_xl_req_vld        <= 1'b0;
                            r_state             <= RESP;
                        end else if (w_timeout) begin
                            // Faulting answer reports the untranslated address.
                            r_translated_addr   <= r_xl_addr;
                            r_excp_code         <= r_xl_write ? ST_FAULT_CODE : LD_FAULT_CODE;
                            r_excp_code_vld     <= 1'b1;
                            r_ans_vld[r_grant]  <= 1'b1;
                            r_xl_req_vld        <= 1'b0;
                            r_state             <= RESP;
                        end else if (r_wait_cnt != '1) begin
                            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                        end
                    end
                    RESP:    r_state <= IDLE;
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign xl_req_vld_o      = r_xl_req_vld;
    assign xl_addr_o         = r_xl_addr;
    assign xl_write_o        = r_xl_write;
    assign ans_vld_o         = r_ans_vld;
    assign translated_addr_o = r_translated_addr;
    assign excp_code_o       = r_excp_code;
    assign excp_code_vld_o   = r_excp_code_vld;
    assign grant_o           = r_grant;

endmodule

// File: tb/tb_agu_xlate_arbiter.sv
// Directed bench for agu_xlate_arbiter: arbitration order, latency, timeout
// faults, flush and reset behaviour, all against hand-computed values.
module tb_agu_xlate_arbiter;

    logic        clk_sys;
    logic        rst_b;
    logic        flush_i;
    logic [1:0]  virt_addr_vld_i;
    logic [31:0] virt_addr0_i;
    logic [31:0] virt_addr1_i;
    logic [1:0]  isWrite_i;
    logic        xl_req_vld_o;
    logic [31:0] xl_addr_o;
    logic        xl_write_o;
    logic        ans_vld_i;
    logic [31:0] translated_addr_i;
    logic [3:0]  excp_code_i;
    logic        excp_code_vld_i;
    logic [1:0]  ans_vld_o;
    logic [31:0] translated_addr_o;
    logic [3:0]  excp_code_o;
    logic        excp_code_vld_o;
    logic        grant_o;

    int n_cmp = 0;
    int n_err = 0;

    agu_xlate_arbiter #(
        .TIMEOUT_CYCLES (16),
        .LD_FAULT_CODE  (4'd5),
        .ST_FAULT_CODE  (4'd7)
    ) dut (
        .cpu_clock_i       (clk_sys),
        .cpu_reset_n_i     (rst_b),
        .flush_i           (flush_i),
        .virt_addr_vld_i   (virt_addr_vld_i),
        .virt_addr0_i      (virt_addr0_i),
        .virt_addr1_i      (virt_addr1_i),
        .isWrite_i         (isWrite_i),
        .xl_req_vld_o      (xl_req_vld_o),
        .xl_addr_o         (xl_addr_o),
        .xl_write_o        (xl_write_o),
        .ans_vld_i         (ans_vld_i),
        .translated_addr_i (translated_addr_i),
        .excp_code_i       (excp_code_i),
        .excp_code_vld_i   (excp_code_vld_i),
        .ans_vld_o         (ans_vld_o),
        .translated_addr_o (translated_addr_o),
        .excp_code_o       (excp_code_o),
        .excp_code_vld_o   (excp_code_vld_o),
        .grant_o           (grant_o)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance past one rising edge; outputs are then stable for sampling.
    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Grants AGU0, withholds the answer for 16 WAIT cycles, optionally
    // answering on the timeout cycle itself.
    task automatic run_timeout(input logic wr, input logic coincide, input logic [31:0] addr,
                               input logic [31:0] exp_addr, input logic [3:0] exp_code,
                               input logic exp_evld);
        virt_addr_vld_i = 2'b01;
        virt_addr0_i    = addr;
        isWrite_i       = {1'b0, wr};
        tick();
        chk("to_req", {31'd0, xl_req_vld_o}, 32'd1);
        chk("to_write", {31'd0, xl_write_o}, {31'd0, wr});
        for (int i = 0; i < 15; i++) tick();
        chk("to_req_last", {31'd0, xl_req_vld_o}, 32'd1);
        chk("to_no_pulse", {30'd0, ans_vld_o}, 32'd0);
        if (coincide) begin
            ans_vld_i         = 1'b1;
            translated_addr_i = 32'h5555_0000;
            excp_code_i       = 4'd0;
            excp_code_vld_i   = 1'b0;
        end
        tick();
        ans_vld_i       = 1'b0;
        virt_addr_vld_i = 2'b00;
        chk("to_pulse", {30'd0, ans_vld_o}, 32'd1);
        chk("to_addr", translated_addr_o, exp_addr);
        chk("to_code", {28'd0, excp_code_o}, {28'd0, exp_code});
        chk("to_evld", {31'd0, excp_code_vld_o}, {31'd0, exp_evld});
        chk("to_req_clr", {31'd0, xl_req_vld_o}, 32'd0);
        tick();
    endtask

    initial begin
        logic exp_g;
        rst_b             = 1'b0;
        flush_i           = 1'b0;
        virt_addr_vld_i   = 2'b00;
        virt_addr0_i      = 32'h0;
        virt_addr1_i      = 32'h0;
        isWrite_i         = 2'b00;
        ans_vld_i         = 1'b0;
        translated_addr_i = 32'h0;
        excp_code_i       = 4'd0;
        excp_code_vld_i   = 1'b0;
        tick();
        tick();
        chk("rst_req", {31'd0, xl_req_vld_o}, 32'd0);
        chk("rst_ans", {30'd0, ans_vld_o}, 32'd0);
        chk("rst_grant", {31'd0, grant_o}, 32'd0);
        chk("rst_addr", xl_addr_o, 32'd0);

        // Both AGUs request out of reset, answered immediately.
        rst_b           = 1'b1;
        virt_addr_vld_i = 2'b11;
        virt_addr0_i    = 32'h0000_1000;
        virt_addr1_i    = 32'h0000_2000;
        tick();                                             // cycle 1
        chk("c1_req", {31'd0, xl_req_vld_o}, 32'd1);
        chk("c1_grant", {31'd0, grant_o}, 32'd0);
        chk("c1_addr", xl_addr_o, 32'h0000_1000);
        ans_vld_i         = 1'b1;
        translated_addr_i = 32'h1111_0000;
        excp_code_i       = 4'd2;
        excp_code_vld_i   = 1'b0;
        tick();                                             // cycle 2
        ans_vld_i       = 1'b0;
        virt_addr_vld_i = 2'b10;
        chk("c2_pulse", {30'd0, ans_vld_o}, 32'd1);
        chk("c2_taddr", translated_addr_o, 32'h1111_0000);
        chk("c2_req", {31'd0, xl_req_vld_o}, 32'd0);
        tick();                                             // cycle 3
        chk("c3_pulse", {30'd0, ans_vld_o}, 32'd0);
        chk("c3_req", {31'd0, xl_req_vld_o}, 32'd0);
        tick();                                             // cycle 4
        chk("c4_req", {31'd0, xl_req_vld_o}, 32'd1);
        chk("c4_addr", xl_addr_o, 32'h0000_2000);
        chk("c4_grant", {31'd0, grant_o}, 32'd1);
        ans_vld_i         = 1'b1;
        translated_addr_i = 32'h2222_0000;
        tick();                                             // cycle 5
        ans_vld_i       = 1'b0;
        virt_addr_vld_i = 2'b00;
        chk("c5_pulse", {30'd0, ans_vld_o}, 32'd2);
        chk("c5_taddr", translated_addr_o, 32'h2222_0000);
        tick();

        // Continuous contention: eight grants alternate starting with AGU0.
        virt_addr_vld_i = 2'b11;
        exp_g = 1'b0;
        for (int g = 0; g < 8; g++) begin
            for (int k = 0; k < 10 && !xl_req_vld_o; k++) tick();
            chk("rr_req", {31'd0, xl_req_vld_o}, 32'd1);
            chk("rr_grant", {31'd0, grant_o}, {31'd0, exp_g});
            ans_vld_i = 1'b1;
            tick();
            ans_vld_i = 1'b0;
            chk("rr_pulse", {30'd0, ans_vld_o}, exp_g ? 32'd2 : 32'd1);
            exp_g = ~exp_g;
        end
        virt_addr_vld_i = 2'b00;
        tick();
        tick();

        // AGU1 store, answer delayed three cycles.
        virt_addr_vld_i = 2'b10;
        virt_addr1_i    = 32'h8000_0000;
        isWrite_i       = 2'b10;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("st_hold_req", {31'd0, xl_req_vld_o}, 32'd1);
            chk("st_hold_addr", xl_addr_o, 32'h8000_0000);
            tick();
        end
        chk("st_req4", {31'd0, xl_req_vld_o}, 32'd1);
        chk("st_write", {31'd0, xl_write_o}, 32'd1);
        chk("st_no_pulse", {30'd0, ans_vld_o}, 32'd0);
        ans_vld_i         = 1'b1;
        translated_addr_i = 32'h8000_0040;
        excp_code_i       = 4'd0;
        excp_code_vld_i   = 1'b0;
        tick();
        ans_vld_i       = 1'b0;
        virt_addr_vld_i = 2'b00;
        isWrite_i       = 2'b00;
        chk("st_pulse", {30'd0, ans_vld_o}, 32'd2);
        chk("st_taddr", translated_addr_o, 32'h8000_0040);
        chk("st_evld", {31'd0, excp_code_vld_o}, 32'd0);
        tick();

        // Timeouts: load fault, store fault, and a real answer winning the tie.
        run_timeout(1'b0, 1'b0, 32'h0000_ABC0, 32'h0000_ABC0, 4'd5, 1'b1);
        run_timeout(1'b1, 1'b0, 32'h0001_2340, 32'h0001_2340, 4'd7, 1'b1);
        run_timeout(1'b0, 1'b1, 32'h0000_7770, 32'h5555_0000, 4'd0, 1'b0);

        // Stray answer while idle is ignored.
        ans_vld_i         = 1'b1;
        translated_addr_i = 32'hDEAD_0000;
        tick();
        ans_vld_i = 1'b0;
        chk("idle_ans", {30'd0, ans_vld_o}, 32'd0);

        // Flush in WAIT together with an answer; then flush in IDLE blocks the grant.
        virt_addr_vld_i = 2'b01;
        virt_addr0_i    = 32'h0000_4000;
        isWrite_i       = 2'b00;
        tick();
        chk("fl_req", {31'd0, xl_req_vld_o}, 32'd1);
        flush_i   = 1'b1;
        ans_vld_i = 1'b1;
        tick();
        ans_vld_i = 1'b0;
        chk("fl_no_pulse", {30'd0, ans_vld_o}, 32'd0);
        chk("fl_req_clr", {31'd0, xl_req_vld_o}, 32'd0);
        tick();
        chk("fl_idle_block", {31'd0, xl_req_vld_o}, 32'd0);
        flush_i = 1'b0;
        tick();
        chk("fl_regrant", {31'd0, xl_req_vld_o}, 32'd1);
        chk("fl_regrant_g", {31'd0, grant_o}, 32'd0);
        chk("fl_regrant_a", xl_addr_o, 32'h0000_4000);
        ans_vld_i = 1'b1;
        tick();
        ans_vld_i       = 1'b0;
        virt_addr_vld_i = 2'b00;
        chk("fl_pulse", {30'd0, ans_vld_o}, 32'd1);
        tick();

        // Reset mid-WAIT after an AGU0 grant; AGU0 must still win the first tie.
        virt_addr_vld_i = 2'b01;
        virt_addr0_i    = 32'h0000_9000;
        isWrite_i       = 2'b01;
        tick();
        chk("rw_req", {31'd0, xl_req_vld_o}, 32'd1);
        rst_b = 1'b0;
        tick();
        chk("rw_req0", {31'd0, xl_req_vld_o}, 32'd0);
        chk("rw_addr0", xl_addr_o, 32'd0);
        chk("rw_write0", {31'd0, xl_write_o}, 32'd0);
        chk("rw_ans0", {30'd0, ans_vld_o}, 32'd0);
        chk("rw_taddr0", translated_addr_o, 32'd0);
        chk("rw_code0", {28'd0, excp_code_o}, 32'd0);
        chk("rw_evld0", {31'd0, excp_code_vld_o}, 32'd0);
        chk("rw_grant0", {31'd0, grant_o}, 32'd0);
        rst_b           = 1'b1;
        virt_addr_vld_i = 2'b11;
        virt_addr1_i    = 32'h0000_A000;
        tick();
        chk("rw_first_req", {31'd0, xl_req_vld_o}, 32'd1);
        chk("rw_first_grant", {31'd0, grant_o}, 32'd0);
        chk("rw_first_addr", xl_addr_o, 32'h0000_9000);
        virt_addr_vld_i = 2'b00;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
